signal_shrink: RTL and testbench

Pulse-width decoder and the receiving end of `signal_extend`. It samples a stretched `vld`/`vld_data` level, checks that the high phase lasted the agreed number of cycles within a tolerance, and recovers one single-cycle event carrying the transported data bit. Pulses that are too short, too long, or carry changing data are reported as errors. It sits at the receive side of slow control and status paths, in the same clock domain as the extender.

---
 rtl/signal_shrink_pkg.sv | 14 +
 rtl/signal_shrink.sv | 110 +++++++++++
 tb/tb_signal_shrink.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/signal_shrink_pkg.sv
// signal_shrink_pkg: shared state encoding and counter width helper for signal_shrink
package signal_shrink_pkg;

    typedef enum logic [1:0] {
        WAIT_REL,
        IDLE,
        MEAS
    } sig_shrink_st_e;

    function automatic int cnt_width(input int max_w);
        return $clog2(max_w + 1);
    endfunction

endpackage

// File: rtl/signal_shrink.sv
// signal_shrink: decodes a stretched vld/vld_data level into one single-cycle event with width/data checks
//   i_clk, i_rst (async, active-high)
//   i_vld, i_vld_data          : stretched level and the data bit it carries
//   o_vld, o_vld_data          : one-cycle good-pulse event and its recovered data
//   o_short_err, o_long_err    : one-cycle width violation pulses
//   o_data_err                 : one-cycle data-changed pulse (only with SIGNAL_SHRINK_DATA_CHK_EN)
//   o_busy                     : measuring a pulse or waiting for the level to drop
module signal_shrink
    import signal_shrink_pkg::*;
#(
    parameter int EXTEND_CYC_NUM = 12,
    parameter int TOL_CYC_NUM    = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vld,
    input  logic i_vld_data,
    output logic o_vld,
    output logic o_vld_data,
    output logic o_short_err,
    output logic o_long_err,
    output logic o_data_err,
    output logic o_busy
);

    localparam int MIN_W = EXTEND_CYC_NUM - TOL_CYC_NUM;
    localparam int MAX_W = EXTEND_CYC_NUM + TOL_CYC_NUM;
    localparam int CNT_W = cnt_width(MAX_W);

    sig_shrink_st_e st, st_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic data_ref, ref_nxt;
    logic data_mis;
    logic vld_nxt, vdata_nxt, short_nxt, long_nxt, derr_nxt;

`ifdef SIGNAL_SHRINK_DATA_CHK_EN
    // Accumulates only while sampling high inside MEAS; any other state leaves it cleared.
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            data_mis <= 1'b0;
        else
            data_mis <= (st == MEAS) && i_vld && (data_mis || (i_vld_data != data_ref));
`else
    assign data_mis = 1'b0;
`endif

    always_comb begin
        st_nxt    = st;
        cnt_nxt   = cnt;
        ref_nxt   = data_ref;
        vld_nxt   = 1'b0;
        vdata_nxt = 1'b0;
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
        derr_nxt  = 1'b0;
        case (st)
            WAIT_REL: if (!i_vld) begin
                st_nxt  = IDLE;
                cnt_nxt = '0;
                ref_nxt = 1'b0;
            end
            IDLE: if (i_vld) begin
                st_nxt  = MEAS;
                cnt_nxt = CNT_W'(1);
                ref_nxt = i_vld_data;
            end
            MEAS: if (i_vld) begin
                // Saturating at MAX_W means the next high sample is the first one too many.
                if (cnt == CNT_W'(MAX_W)) begin
                    long_nxt = 1'b1;
                    st_nxt   = WAIT_REL;
                end else
                    cnt_nxt = cnt + CNT_W'(1);
            end else begin
                st_nxt    = IDLE;
                cnt_nxt   = '0;
                ref_nxt   = 1'b0;
                short_nxt = cnt < CNT_W'(MIN_W);
                derr_nxt  = !short_nxt && data_mis;
                vld_nxt   = !short_nxt && !data_mis;
                vdata_nxt = vld_nxt && data_ref;
            end
            default: st_nxt = WAIT_REL;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            st          <= WAIT_REL;
            cnt         <= '0;
            data_ref    <= 1'b0;
            o_vld       <= 1'b0;
            o_vld_data  <= 1'b0;
            o_short_err <= 1'b0;
            o_long_err  <= 1'b0;
            o_data_err  <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            st          <= st_nxt;
            cnt         <= cnt_nxt;
            data_ref    <= ref_nxt;
            o_vld       <= vld_nxt;
            o_vld_data  <= vdata_nxt;
            o_short_err <= short_nxt;
            o_long_err  <= long_nxt;
            o_data_err  <= derr_nxt;
            o_busy      <= st_nxt != IDLE;
        end

endmodule

// File: tb/tb_signal_shrink.sv
// tb_signal_shrink: randomized and directed checks of signal_shrink against a run-length reference model
module tb_signal_shrink;

    localparam int MIN_W = 11;
    localparam int MAX_W = 13;
`ifdef SIGNAL_SHRINK_DATA_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_vld = 1'b0;
    logic i_vld_data = 1'b0;
    logic o_vld, o_vld_data, o_short_err, o_long_err, o_data_err, o_busy;

    signal_shrink #(.EXTEND_CYC_NUM(12), .TOL_CYC_NUM(1)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_vld(i_vld),
        .i_vld_data(i_vld_data),
        .o_vld(o_vld),
        .o_vld_data(o_vld_data),
        .o_short_err(o_short_err),
        .o_long_err(o_long_err),
        .o_data_err(o_data_err),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    wire [5:0] obs = {o_vld, o_vld_data, o_short_err, o_long_err, o_data_err, o_busy};

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit armed = 1'b0;
    int run = 0;
    bit first = 1'b0;
    bit changed = 1'b0;
    logic [5:0] exp_v = '0;
    bit [1:0] stim[$];

    // Reference: a pulse is the run of consecutive high samples seen after at least one low
    // sample since reset; it is judged by its length and whether its data ever differed.
    task automatic tick(input bit v, input bit d);
        bit e_vld, e_vd, e_sh, e_lg, e_de;
        @(negedge i_clk);
        i_vld = v;
        i_vld_data = d;
        @(posedge i_clk);
        cyc++;
        {e_vld, e_vd, e_sh, e_lg, e_de} = '0;
        if (i_rst) begin
            armed = 1'b0;
            run = 0;
            changed = 1'b0;
            exp_v = '0;
        end else begin
            if (!armed) begin
                if (!v) armed = 1'b1;
            end else if (v) begin
                run++;
                if (run == 1) first = d;
                else if (d != first) changed = 1'b1;
                if (run == MAX_W + 1) e_lg = 1'b1;
            end else begin
                if (run > 0 && run <= MAX_W) begin
                    if (run < MIN_W) e_sh = 1'b1;
                    else if (CHK && changed) e_de = 1'b1;
                    else begin
                        e_vld = 1'b1;
                        e_vd = first;
                    end
                end
                run = 0;
                changed = 1'b0;
            end
            exp_v = {e_vld, e_vd, e_sh, e_lg, e_de, v};
        end
        #1;
    endtask

    task automatic add_pulse(input int w, input bit d, input int tog, input int low);
        for (int i = 1; i <= w; i++) stim.push_back({1'b1, (tog > 0 && i >= tog) ? ~d : d});
        for (int i = 0; i < low; i++) stim.push_back(2'b00);
    endtask

    task automatic test_reset();
        repeat (3) begin
            tick(1'b0, 1'b0);
            total++;
            if (obs !== 6'b0) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, obs, 6'b0);
            end
        end
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_nominal();
        int nv = 0;
        add_pulse(0, 1'b0, 0, 2);
        add_pulse(12, 1'b1, 0, 3);
        while (stim.size() > 0) begin
            bit [1:0] s = stim.pop_front();
            tick(s[1], s[0]);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL nominal cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            if (o_vld && o_vld_data) nv++;
        end
        total++;
        if (nv !== 1) begin
            bad++;
            $display("FAIL nominal_count got=%0d exp=1", nv);
        end
    endtask

    task automatic test_tolerance();
        int nv = 0, ns = 0;
        add_pulse(11, 1'b0, 0, 2);
        add_pulse(13, 1'b0, 0, 2);
        add_pulse(10, 1'b1, 0, 2);
        add_pulse(3, 1'b1, 0, 2);
        while (stim.size() > 0) begin
            bit [1:0] s = stim.pop_front();
            tick(s[1], s[0]);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL tolerance cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            if (o_vld && !o_vld_data) nv++;
            if (o_short_err) ns++;
        end
        total++;
        if (nv !== 2 || ns !== 2) begin
            bad++;
            $display("FAIL tolerance_count got=%0d/%0d exp=2/2", nv, ns);
        end
    endtask

    task automatic test_stuck_high();
        int nl = 0, nv = 0;
        add_pulse(30, 1'b1, 0, 1);
        add_pulse(12, 1'b0, 0, 2);
        while (stim.size() > 0) begin
            bit [1:0] s = stim.pop_front();
            tick(s[1], s[0]);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL stuck_high cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            if (o_long_err) nl++;
            if (o_vld) nv++;
        end
        total++;
        if (nl !== 1 || nv !== 1) begin
            bad++;
            $display("FAIL stuck_count long=%0d vld=%0d exp=1/1", nl, nv);
        end
    endtask

    task automatic test_data_change();
        int nv = 0, nd = 0;
        add_pulse(12, 1'b1, 6, 3);
        while (stim.size() > 0) begin
            bit [1:0] s = stim.pop_front();
            tick(s[1], s[0]);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL data_change cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            if (o_vld && o_vld_data) nv++;
            if (o_data_err) nd++;
        end
        total++;
        if (nv !== (CHK ? 0 : 1) || nd !== (CHK ? 1 : 0)) begin
            bad++;
            $display("FAIL data_change_count vld=%0d derr=%0d", nv, nd);
        end
    endtask

    task automatic test_back_to_back();
        int hits[$];
        add_pulse(12, 1'b1, 0, 1);
        add_pulse(12, 1'b0, 0, 3);
        while (stim.size() > 0) begin
            bit [1:0] s = stim.pop_front();
            tick(s[1], s[0]);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            if (o_vld) hits.push_back(cyc);
        end
        total++;
        if (hits.size() != 2 || hits[1] - hits[0] != 13) begin
            bad++;
            $display("FAIL back_to_back_gap count=%0d exp=2 gap=13", hits.size());
        end
    endtask

    task automatic test_reset_mid();
        int ns = 0, nv = 0;
        tick(1'b0, 1'b0);
        repeat (4) tick(1'b1, 1'b1);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        armed = 1'b0;
        run = 0;
        changed = 1'b0;
        total++;
        if (obs !== 6'b0) begin
            bad++;
            $display("FAIL reset_async got=%b exp=%b", obs, 6'b0);
        end
        repeat (3) tick(1'b1, 1'b1);
        @(negedge i_clk);
        i_rst = 1'b0;
        add_pulse(6, 1'b1, 0, 2);
        add_pulse(12, 1'b1, 0, 2);
        while (stim.size() > 0) begin
            bit [1:0] s = stim.pop_front();
            tick(s[1], s[0]);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            if (o_short_err) ns++;
            if (o_vld) nv++;
        end
        total++;
        if (ns !== 0 || nv !== 1) begin
            bad++;
            $display("FAIL reset_mid_count short=%0d vld=%0d exp=0/1", ns, nv);
        end
    endtask

    task automatic test_random();
        repeat (60) begin
            int w = $urandom_range(1, 17);
            int tog = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 12) : 0;
            add_pulse(w, 1'($urandom_range(0, 1)), tog, $urandom_range(1, 4));
        end
        while (stim.size() > 0) begin
            bit [1:0] s = stim.pop_front();
            tick(s[1], s[0]);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_tolerance();
        test_stuck_high();
        test_data_change();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
